// File: rtl/frame_tx_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : frame_tx_arb
//  Description : Round-robin arbiter/sequencer sharing one frame_tx between N
//                sources, with inter-frame gap and maximum-length guard.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_tx_arb #(
    parameter int N       = 3,
    parameter int IFG     = 12,
    parameter int MAX_LEN = 1514
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   done,
    output logic [N-1:0]   src_fs,
    input  logic [N-1:0]   src_fd,
    input  logic [8*N-1:0] src_txd,
    output logic [N-1:0]   grant,
    output logic           err_len,
    output logic           tx_fs,
    input  logic           tx_fd,
    input  logic           tx_rdy,
    input  logic           tx_fs_mac,
    output logic           tx_fd_mac,
    output logic [7:0]     tx_mac_txd
);

    localparam int SW = $clog2(N);
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int GW = $clog2(IFG + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_FIN  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t        r_state;
    logic [SW-1:0] r_sel;
    logic [SW-1:0] r_last;
    logic [N-1:0]  r_grant;
    logic [N-1:0]  r_done;
    logic          r_tx_fs;
    logic          r_err;
    logic          r_force;
    logic [CW-1:0] r_cnt;
    logic [GW-1:0] r_gap;

    logic [SW-1:0] w_pick;
    logic [SW:0]   w_sum;
    logic          w_found;
    logic [N-1:0]  w_onehot;
    logic          w_any;
    logic          w_fd_mac;

    // Scan last+1, last+2, ... (mod N) and take the first requester found.
    always_comb begin
        w_pick  = r_last;
        w_found = 1'b0;
        w_sum   = '0;
        for (int j = 0; j < N; j++) begin
            w_sum = {1'b0, r_last} + (SW+1)'(j + 1);
            if (w_sum >= (SW+1)'(N)) begin
                w_sum = w_sum - (SW+1)'(N);
            end
            if (!w_found && req[w_sum[SW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[SW-1:0];
            end
        end
    end

    always_comb begin
        w_onehot         = '0;
        w_onehot[w_pick] = 1'b1;
    end

    // Grant is non-zero exactly while a frame is owned (SEND and FIN).
    assign w_any      = |r_grant;
    assign w_fd_mac   = w_any & (src_fd[r_sel] | r_force);
    assign tx_fd_mac  = w_fd_mac;
    assign tx_mac_txd = w_any ? src_txd[{r_sel, 3'b000} +: 8] : 8'd0;
    assign src_fs     = {N{tx_fs_mac}} & r_grant;

    assign grant   = r_grant;
    assign done    = r_done;
    assign tx_fs   = r_tx_fs;
    assign err_len = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sel   <= SW'(N - 1);
            r_last  <= SW'(N - 1);
            r_grant <= '0;
            r_done  <= '0;
            r_tx_fs <= 1'b0;
            r_err   <= 1'b0;
            r_force <= 1'b0;
            r_cnt   <= '0;
            r_gap   <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt   <= '0;
                    r_force <= 1'b0;
                    if (tx_rdy && (|req)) begin
                        r_sel   <= w_pick;
                        r_last  <= w_pick;
                        r_grant <= w_onehot;
                        r_tx_fs <= 1'b1;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (tx_fd) begin
                        r_tx_fs <= 1'b0;
                        r_done  <= r_grant;
                        r_force <= 1'b0;
                        r_state <= S_FIN;
                    end else begin
                        // Length limit reached: close the frame ourselves.
                        if ((r_cnt == CW'(MAX_LEN)) && !r_force) begin
                            r_force <= 1'b1;
                            r_err   <= 1'b1;
                        end
                        if (tx_fs_mac && !w_fd_mac && (r_cnt != CW'(MAX_LEN))) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    if (!req[r_sel]) begin
                        r_done  <= '0;
                        r_grant <= '0;
                        r_gap   <= '0;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap == GW'(IFG - 1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
